// File: rtl/r0_pkg.sv
// r0_pkg -- shared definitions for the R0 issue controller.
//   opcode_e        : opcode encoding presented to the R0 arithmetic multiplexer
//   state_e         : issue-controller FSM encoding
//   TIMEOUT_DEFAULT : default number of WAIT cycles before an operation is abandoned
//   capture_result  : maps the multiplexer's two result bytes onto {res_hi, res_lo}
package r0_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_NEG = 2'd3
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int TIMEOUT_DEFAULT = 32;

  // MUL yields a 16-bit product split over both result bytes; every other
  // operation is 8 bits wide and arrives on out1 only.
  function automatic logic [15:0] capture_result(opcode_e op,
                                                 logic [7:0] out1,
                                                 logic [7:0] out2);
    return (op == OP_MUL) ? {out1, out2} : {8'h00, out1};
  endfunction

endpackage

// File: rtl/r0_wait_timer.sv
// r0_wait_timer -- WAIT-phase cycle counter for the R0 issue controller.
//   clk, rst_n : clock and asynchronous active-low reset
//   clear      : zero the count (asserted in ISSUE)
//   inc        : count one WAIT cycle
//   expired    : the increment in progress takes the count to TIMEOUT, i.e.
//                this is the TIMEOUT-th WAIT cycle
module r0_wait_timer
  import r0_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation order cannot change the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != CW'(TIMEOUT))) begin
      count <= count + 1'b1;
    end
  end

  // Flagged one count early so the controller can leave WAIT on the same
  // edge that the count reaches TIMEOUT.
  assign expired = inc && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/r0_issue_controller.sv
// r0_issue_controller -- issues one arithmetic operation at a time to the R0
// arithmetic multiplexer, waits (bounded) for completion and hands the result
// to the register-file write stage.
//   clk, rst_n                       : clock, asynchronous active-low reset
//   op_valid, op_ready               : upstream request handshake
//   opcode, operand_a, operand_b     : request (0=ADD 1=SUB 2=MUL 3=NEG)
//   mux_en, mux_state,
//   mux_value1, mux_value2           : drive to the R0 arithmetic multiplexer
//   mux_ready, mux_out1, mux_out2    : completion flag and results from it
//   res_valid, res_hi, res_lo,
//   timeout_err, res_accept          : result handshake to the write stage
module r0_issue_controller
  import r0_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [1:0] opcode,
  input  logic [7:0] operand_a,
  input  logic [7:0] operand_b,
  output logic       mux_en,
  output logic [1:0] mux_state,
  output logic [7:0] mux_value1,
  output logic [7:0] mux_value2,
  input  logic       mux_ready,
  input  logic [7:0] mux_out1,
  input  logic [7:0] mux_out2,
  output logic       res_valid,
  output logic [7:0] res_hi,
  output logic [7:0] res_lo,
  output logic       timeout_err,
  input  logic       res_accept
);

  state_e     state;
  opcode_e    op_q;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic       expire;

  r0_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state == ST_ISSUE),
    .inc     (state == ST_WAIT),
    .expired (expire)
  );

  // NOTE: the operand registers are reset along with the FSM so the mux drive
  // outputs read zero during reset rather than whatever was last issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      op_q        <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      mux_en      <= 1'b0;
      res_valid   <= 1'b0;
      res_hi      <= '0;
      res_lo      <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (op_valid) begin
            op_q   <= opcode_e'(opcode);
            a_q    <= operand_a;
            b_q    <= operand_b;
            mux_en <= 1'b1;
            state  <= ST_ISSUE;
          end
        end

        // mux_ready may still be high from the previous operation, so it is
        // not looked at here; the timer is cleared by decode of this state.
        ST_ISSUE: begin
          state <= ST_WAIT;
        end

        // Completion wins over timeout when both happen on the same edge.
        ST_WAIT: begin
          if (mux_ready) begin
            {res_hi, res_lo} <= capture_result(op_q, mux_out1, mux_out2);
            mux_en           <= 1'b0;
            res_valid        <= 1'b1;
            state            <= ST_DONE;
          end else if (expire) begin
            res_hi      <= '0;
            res_lo      <= '0;
            timeout_err <= 1'b1;
            mux_en      <= 1'b0;
            res_valid   <= 1'b1;
            state       <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (res_accept) begin
            res_valid   <= 1'b0;
            timeout_err <= 1'b0;
            state       <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  // Held low while reset is asserted even though the FSM already sits in IDLE.
  assign op_ready   = rst_n && (state == ST_IDLE);
  assign mux_state  = op_q;
  assign mux_value1 = a_q;
  assign mux_value2 = b_q;

endmodule

// File: tb/tb_r0_issue_controller.sv
module tb_r0_issue_controller;
  import r0_pkg::*;

  localparam int TO = 4;

  logic       clk;
  logic       rst_n;
  logic       op_valid;
  logic       op_ready;
  logic [1:0] opcode;
  logic [7:0] operand_a;
  logic [7:0] operand_b;
  logic       mux_en;
  logic [1:0] mux_state;
  logic [7:0] mux_value1;
  logic [7:0] mux_value2;
  logic       mux_ready;
  logic [7:0] mux_out1;
  logic [7:0] mux_out2;
  logic       res_valid;
  logic [7:0] res_hi;
  logic [7:0] res_lo;
  logic       timeout_err;
  logic       res_accept;

  r0_issue_controller #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .opcode      (opcode),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .mux_en      (mux_en),
    .mux_state   (mux_state),
    .mux_value1  (mux_value1),
    .mux_value2  (mux_value2),
    .mux_ready   (mux_ready),
    .mux_out1    (mux_out1),
    .mux_out2    (mux_out2),
    .res_valid   (res_valid),
    .res_hi      (res_hi),
    .res_lo      (res_lo),
    .timeout_err (timeout_err),
    .res_accept  (res_accept)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0] hi;
    logic [7:0] lo;
    logic       err;
    int         cycle;
  } exp_t;

  exp_t sb[$];

  // Operation currently expected on the mux drive outputs.
  logic [1:0] cur_op = '0;
  logic [7:0] cur_a  = '0;
  logic [7:0] cur_b  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference: what the write stage must see for an operation whose mux
  // answer arrives on WAIT sample k (k > TO means it never arrives in time).
  function automatic exp_t model(input logic [1:0] opc, input logic [7:0] a,
                                 input logic [7:0] b, input int k, input int nacc);
    exp_t e;
    logic [15:0] full;
    case (opc)
      2'd0:    full = {8'h00, 8'(a + b)};
      2'd1:    full = {8'h00, 8'(a - b)};
      2'd2:    full = 16'(a) * 16'(b);
      default: full = {8'h00, 8'(8'd0 - a)};
    endcase
    if (k > TO) begin
      e.hi = 8'h00; e.lo = 8'h00; e.err = 1'b1; e.cycle = nacc + TO + 1;
    end else begin
      e.hi = full[15:8]; e.lo = full[7:0]; e.err = 1'b0; e.cycle = nacc + k + 1;
    end
    return e;
  endfunction

  // Monitor: pops an expectation when res_valid rises, then checks the held
  // result and the DONE-state outputs every cycle it stays valid.
  initial begin
    exp_t cur;
    bit   have_cur   = 0;
    bit   prev_valid = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 0;
        have_cur   = 0;
      end else begin
        if (res_valid && !prev_valid) begin
          if (sb.size() == 0) begin
            fail("spurious_res_valid");
          end else begin
            cur      = sb.pop_front();
            have_cur = 1;
            check("res_latency", cyc, cur.cycle);
          end
        end
        if (res_valid && have_cur) begin
          check("res_hi", res_hi, cur.hi);
          check("res_lo", res_lo, cur.lo);
          check("timeout_err", timeout_err, cur.err);
          check("done_op_ready", op_ready, 0);
          check("done_mux_en", mux_en, 0);
        end
        if (!res_valid) have_cur = 0;
        if (mux_en) begin
          check("mux_state", mux_state, cur_op);
          check("mux_value1", mux_value1, cur_a);
          check("mux_value2", mux_value2, cur_b);
        end
        prev_valid = res_valid;
      end
    end
  end

  // Present a request and wait (bounded) until it is taken; returns 0 if not.
  task automatic request(input logic [1:0] opc, input logic [7:0] a,
                         input logic [7:0] b, output bit ok, output int nacc);
    int waited = 0;
    op_valid  = 1'b1;
    opcode    = opc;
    operand_a = a;
    operand_b = b;
    while (!op_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    ok = op_ready;
    if (!ok) begin
      fail("accept_timeout");
      op_valid = 1'b0;
      nacc = 0;
      return;
    end
    @(posedge clk); #1;
    nacc   = cyc;
    cur_op = opc;
    cur_a  = a;
    cur_b  = b;
    // Upstream changes after acceptance must not reach the mux drive.
    op_valid  = 1'b0;
    opcode    = 2'($urandom);
    operand_a = 8'($urandom);
    operand_b = 8'($urandom);
  endtask

  // One full operation: the mux answers on WAIT sample k; with stale set its
  // previous ready/result is left standing through ISSUE. The result is held
  // for 'hold' cycles with op_valid high before being accepted.
  task automatic run_op(input logic [1:0] opc, input logic [7:0] a, input logic [7:0] b,
                        input int k, input bit stale, input int hold);
    bit          ok;
    int          nacc;
    logic [15:0] p;
    logic [7:0]  r1;
    logic [7:0]  r2;
    r2 = 8'($urandom);
    case (opc)
      2'd0:    r1 = a + b;
      2'd1:    r1 = a - b;
      2'd2:    begin p = 16'(a) * 16'(b); r1 = p[15:8]; r2 = p[7:0]; end
      default: r1 = 8'd0 - a;
    endcase
    request(opc, a, b, ok, nacc);
    if (!ok) return;
    sb.push_back(model(opc, a, b, k, nacc));
    // ISSUE cycle
    check("issue_mux_en", mux_en, 1);
    check("issue_op_ready", op_ready, 0);
    res_accept = 1'($urandom);
    if (!stale) begin
      mux_ready = 1'b0;
      mux_out1  = 8'($urandom);
      mux_out2  = 8'($urandom);
    end
    for (int j = 1; j <= TO && j <= k; j++) begin
      @(posedge clk); #1;
      check("wait_mux_en", mux_en, 1);
      res_accept = 1'($urandom);
      if (j == k) begin
        mux_ready = 1'b1; mux_out1 = r1; mux_out2 = r2;
      end else begin
        mux_ready = 1'b0; mux_out1 = 8'($urandom); mux_out2 = 8'($urandom);
      end
    end
    @(posedge clk); #1;
    op_valid   = 1'b1;
    res_accept = 1'b0;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    res_accept = 1'b1;
    @(posedge clk); #1;
    res_accept = 1'b0;
    op_valid   = 1'b0;
    check("ready_after_accept", op_ready, 1);
  endtask

  task automatic reset_mid_wait();
    bit ok;
    int nacc;
    request(2'd2, 8'($urandom), 8'($urandom), ok, nacc);
    if (!ok) return;
    mux_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("rst_mux_en", mux_en, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_op_ready", op_ready, 0);
    check("rst_mux_value1", mux_value1, 0);
    check("rst_mux_state", mux_state, 0);
    // A completion arriving now belongs to the discarded operation.
    mux_ready = 1'b1;
    mux_out1  = 8'hAA;
    mux_out2  = 8'h55;
    @(posedge clk); #1;
    check("rst_hold_res_valid", res_valid, 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_op_ready", op_ready, 1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("post_rst_res_valid", res_valid, 0);
  endtask

  initial begin
    int waited;
    rst_n      = 1'b0;
    op_valid   = 1'b0;
    opcode     = '0;
    operand_a  = '0;
    operand_b  = '0;
    mux_ready  = 1'b0;
    mux_out1   = '0;
    mux_out2   = '0;
    res_accept = 1'b0;
    #1;
    check("reset_op_ready", op_ready, 0);
    check("reset_mux_en", mux_en, 0);
    check("reset_res_valid", res_valid, 0);
    check("reset_outputs", {mux_state, mux_value1, mux_value2, res_hi, res_lo, timeout_err},
          0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("reset_release_op_ready", op_ready, 1);

    run_op(2'd0, 8'd25, 8'd17, 3, 0, 0);        // ADD -> 42
    run_op(2'd2, 8'd20, 8'd13, 2, 0, 1);        // MUL -> 0x0104
    run_op(2'd1, 8'd90, 8'd33, 1, 1, 0);        // stale ready through ISSUE
    run_op(2'd3, 8'd5,  8'd0,  TO + 5, 0, 0);   // timeout
    run_op(2'd0, 8'd200, 8'd100, TO, 0, 10);    // ready on the TIMEOUT edge + back-pressure
    reset_mid_wait();
    run_op(2'd3, 8'd7, 8'd9, 2, 0, 0);          // normal after reset

    for (int i = 0; i < 60; i++) begin
      logic [1:0] opc;
      int         k;
      bit         stale;
      opc   = 2'($urandom);
      k     = $urandom_range(1, TO + 2);
      stale = (($urandom % 4) == 0) && mux_ready;
      if (stale) k = 1;
      run_op(opc, 8'($urandom), 8'($urandom), k, stale, $urandom_range(0, 3));
    end

    waited = 0;
    while (sb.size() != 0 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    check("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/r0_issue_controller.md
R0_ISSUE_CONTROLLER -- requirements
Module: r0_issue_controller

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 32, giving the maximum number of WAIT cycles before the result-unit operation is abandoned.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port op_valid, input, 1 bit: upstream request present.
REQ-005 The block SHALL have port op_ready, output, 1 bit: controller can accept a request.
REQ-006 The block SHALL have port opcode, input, 2 bits: 0=ADD, 1=SUB, 2=MUL, 3=NEG.
REQ-007 The block SHALL have ports operand_a and operand_b, input, 8 bits each: operands.
REQ-008 The block SHALL have ports mux_en (output, 1), mux_state (output, 2), mux_value1 and mux_value2 (output, 8 each): drive to the downstream R0 arithmetic multiplexer.
REQ-009 The block SHALL have ports mux_ready (input, 1), mux_out1 and mux_out2 (input, 8 each): completion flag and results from the R0 arithmetic multiplexer.
REQ-010 The block SHALL have ports res_valid (output, 1), res_hi and res_lo (output, 8 each), and timeout_err (output, 1): result to the register-file write stage.
REQ-011 The block SHALL have port res_accept, input, 1 bit: the write stage consumes the result.

Function
REQ-012 The FSM SHALL have four states: IDLE, ISSUE, WAIT and DONE.
REQ-013 IDLE: op_ready=1 and mux_en=0; on op_valid=1, the block SHALL register opcode, operand_a and operand_b, then go to ISSUE.
REQ-014 ISSUE: mux_en=1 and mux_state/value1/value2 come from the registered copies; mux_ready SHALL be ignored (it may be stale from the previous op); the wait counter SHALL be cleared; then go to WAIT.
REQ-015 WAIT: mux_en=1 and the counter increments each cycle; on mux_ready=1 the block SHALL capture the result and go to DONE.
REQ-016 Capture rule: for MUL, res_hi=mux_out1 and res_lo=mux_out2; for ADD/SUB/NEG, res_hi=0 and res_lo=mux_out1.
REQ-017 WAIT timeout: if the counter reaches TIMEOUT with mux_ready=0, the block SHALL set res_hi=res_lo=0 and timeout_err=1, then go to DONE.
REQ-018 DONE: res_valid=1, mux_en=0, op_ready=0, and the results are held stable; on res_accept=1 the block SHALL clear timeout_err and go to IDLE.
REQ-019 Latency: a request accepted at edge N SHALL drive ISSUE in cycle N+1; mux_ready is first sampled at edge N+2; res_valid is earliest high in cycle N+3.
REQ-020 The mux_value1/value2/state outputs SHALL stay constant from ISSUE through DONE, regardless of upstream input changes.
REQ-021 op_valid while not in IDLE SHALL be ignored; there is no bypass, so a request arriving in the same cycle as res_accept in DONE is accepted in the following IDLE cycle.
REQ-022 mux_ready=1 in the same cycle the counter reaches TIMEOUT SHALL be treated as success, not timeout.
REQ-023 res_accept outside DONE SHALL have no effect.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE and set every output to 0 except op_ready, which is 1 only once rst_n=1; the counter and registered operands SHALL clear to 0.
REQ-025 Reset asserted during WAIT SHALL deassert mux_en asynchronously; the in-flight result SHALL be discarded and never presented.

Structure
REQ-026 A shared package r0_pkg SHALL hold the opcode constants (ADD/SUB/MUL/NEG), the FSM state encoding and the TIMEOUT default.
REQ-027 The wait counter SHALL be a sub-module, r0_wait_timer, with clear, increment enable and an expired flag at TIMEOUT.
REQ-028 All outputs SHALL be driven from registers (no combinational path from inputs to outputs), except op_ready, which decodes the IDLE state.

Verification
REQ-029 ADD: opcode=0, a=25, b=17, mux model returns 42 after 3 cycles -> res_valid with res_hi=0, res_lo=42, timeout_err=0.
REQ-030 MUL: opcode=2, a=20, b=13, mux returns out1=0x01, out2=0x04 -> res_hi=0x01, res_lo=0x04.
REQ-031 Stale ready: mux_ready held 1 from the previous op through ISSUE -> not captured in ISSUE; capture occurs at the first WAIT edge.
REQ-032 Timeout: TIMEOUT=4, mux_ready never asserted -> res_valid after 4 WAIT cycles, timeout_err=1, res_hi=res_lo=0.
REQ-033 Back-pressure: res_accept held 0 for 10 cycles with op_valid=1 -> op_ready=0 and the result is unchanged throughout; after accept, the next op issues one cycle later.
REQ-034 Reset mid-WAIT: rst_n pulsed low -> mux_en=0 immediately, res_valid never asserts, and the next op completes normally.
